keypad_scan_debounce: RTL
=========================

Name: keypad_scan_debounce

Overview:
- Upstream front end for the calculator's keypad interface: drives the 4x4 matrix columns, samples the rows and rejects ghosting (multiple simultaneous keys).
- Debounces over whole scans and emits a single-cycle pulse with a 4-bit key code per accepted press.
- Output feeds the key-decode stage that classifies keys as digit, operation or equals.
- Runs on the 6 MHz internal oscillator clock.

Parameters:
- SCAN_DIV, 6000: clock cycles each column is driven (1 ms at 6 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan snapshots required to accept a change; range 1..15.
- REPEAT_DELAY, 500: scans a key must be held before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 100: scans between subsequent auto-repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rows  in  4  matrix rows, active low (pulled up externally), asynchronous to clk
- cols  out  4  column strobes, active low, exactly one bit low at any time
- key_pulse  out  1  one-cycle strobe: new key accepted
- key_code  out  4  code of the accepted key = row*4 + col; stable between pulses
- key_held  out  1  high while an accepted key remains pressed
- scan_done  out  1  one-cycle strobe at the end of each full 4-column scan

Behaviour:
- Reset (asynchronous, active high) sets:
  - cols=4'b1110, column index 0, divider 0
  - synchronizer flops 4'b1111
  - snapshot, candidate and accepted = "none"
  - stable count 0
  - key_pulse=0, key_code=0, key_held=0, scan_done=0
- Rows pass through a 2-flop synchronizer before any use.
- Column slot: the divider counts 0..SCAN_DIV-1.
  - On the last count, the synchronized rows are sampled into a 16-bit snapshot for the current column (bit = ~row).
  - The column index then advances 0→1→2→3→0. cols = ~(1<<index).
- After column 3 is sampled:
  - scan_done pulses.
  - The snapshot is reduced to a candidate: 0 bits set gives none; exactly 1 bit set gives that key's code; 2 or more bits set gives none (ghost rejection).
- Debounce, evaluated once per scan:
  - If the candidate equals the previous scan's candidate, stable count increments, saturating at 15. Otherwise it reloads to 1.
  - When stable count ≥ DEBOUNCE_SCANS and the candidate differs from the accepted value, accepted ← candidate.
- On acceptance:
  - Accepted key is not none: key_code ← code, key_pulse=1 for exactly one cycle in the same clock, key_held=1.
  - Accepted value is none: key_held=0, no pulse, key_code holds its last value.
- Direct change A→B with no intervening none: B is accepted with a fresh pulse once it is stable. key_held stays 1.
- Press latency from the first scan in which the key is seen: DEBOUNCE_SCANS scans + 1 clock (≤ (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles from the physical edge).
- Bounce shorter than DEBOUNCE_SCANS scans never produces a pulse or release.
- Reset mid-scan: everything returns to reset values immediately. No pulse for a key already held at reset until it has been re-accepted via debounce.
- Outputs are registered; key_pulse and scan_done are never high for more than one cycle.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - A 10-bit scan counter runs while key_held=1 and is cleared on any acceptance.
  - After REPEAT_DELAY scans, key_pulse fires again with the same key_code. Thereafter it fires every REPEAT_RATE scans until release or change.
- Undefined: the counter logic is absent and exactly one pulse is produced per accepted press.

Test Plan:
- Bench params SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset then idle rows=4'hF for 10 scans → cols cycles 1110,1101,1011,0111 with 4 cycles each; key_pulse never high; key_held=0.
- Press row1/col2 held clean → exactly one key_pulse, key_code=6, 3 scans after the first detecting scan; key_held=1 until release is stable 3 scans, then 0 with no pulse.
- Bounce row0/col0 toggling every scan for 8 scans, then stable → single pulse with code 0 only after 3 stable scans.
- Hold row2/col1 and row2/col3 together → treated as none, no pulse. Release col3 → pulse with code 9.
- Hold key 15, then switch directly to key 4 → pulses with 15, then 4; key_held stays 1 throughout.
- Assert rst mid-column while key 5 is held → cols=1110 and all outputs 0 within the same cycle. After deassert, pulse with code 5 after 3 stable scans.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=5, REPEAT_RATE=2, holding key 3 → pulses at acceptance, +5 scans, then every 2 scans; they stop at release.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: column strobing, 2-flop row sync, per-scan ghost rejection and debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 6000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_pulse,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       scan_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [4:0] NONE = 5'h10;  // bit 4 set = no valid key

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 1023 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 1023) begin : g_bad_cfg
    $error("keypad_scan_debounce: parameter out of range");
  end

  logic [3:0]       rows_m, rows_s;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [15:0]      snap, snap_nxt;
  logic [4:0]       cand, prev_cand, accepted;
  logic [3:0]       stable_cnt, cnt_nxt;
  logic             slot_end, scan_end, accept, rpt_fire;

  assign cols     = ~(4'b0001 << col_idx);
  assign slot_end = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_end = slot_end && (col_idx == 2'd3);

  // snapshot including the column being sampled this cycle
  always_comb begin
    snap_nxt = snap;
    for (int r = 0; r < 4; r++)
      snap_nxt[{r[1:0], col_idx}] = ~rows_s[r];
  end

  // single key -> its code; zero or several keys -> none
  always_comb begin
    logic [4:0] ones;
    logic [3:0] code;
    ones = '0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_nxt[i]) begin
        ones = ones + 5'd1;
        code = i[3:0];
      end
    end
    cand = (ones == 5'd1) ? {1'b0, code} : NONE;
  end

  assign cnt_nxt = (cand != prev_cand)  ? 4'd1 :
                   (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
  assign accept  = scan_end && (cnt_nxt >= 4'(DEBOUNCE_SCANS)) && (cand != accepted);

`ifdef KEYPAD_REPEAT_EN
  logic [9:0] rep_cnt, rep_inc;
  logic       rep_on;

  assign rep_inc  = rep_cnt + 10'd1;
  assign rpt_fire = scan_end && !accept && key_held &&
                    (rep_on ? (rep_inc == 10'(REPEAT_RATE)) : (rep_inc == 10'(REPEAT_DELAY)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
    end else if (scan_end) begin
      if (accept || !key_held) begin
        rep_cnt <= '0;
        rep_on  <= 1'b0;
      end else if (rpt_fire) begin
        rep_cnt <= '0;
        rep_on  <= 1'b1;
      end else begin
        rep_cnt <= rep_inc;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_m     <= 4'hF;
      rows_s     <= 4'hF;
      div        <= '0;
      col_idx    <= 2'd0;
      snap       <= '0;
      prev_cand  <= NONE;
      accepted   <= NONE;
      stable_cnt <= 4'd0;
      key_pulse  <= 1'b0;
      key_code   <= 4'd0;
      key_held   <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      rows_m    <= rows;
      rows_s    <= rows_m;
      scan_done <= scan_end;
      key_pulse <= (accept && !cand[4]) || rpt_fire;
      if (slot_end) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        snap    <= snap_nxt;
      end else begin
        div <= div + DIV_W'(1);
      end
      if (scan_end) begin
        prev_cand  <= cand;
        stable_cnt <= cnt_nxt;
      end
      if (accept) begin
        accepted <= cand;
        key_held <= !cand[4];
        if (!cand[4]) key_code <= cand[3:0];
      end
    end
  end

endmodule
